// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/MULTU/DIV/DIVU execute unit that commits to HI/LO.
// Optional: define MD_UNIT_MADD_EN to enable MADD/MADDU/MSUB/MSUBU on ops 4-7.
module md_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             md_hazard,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
`ifdef MD_UNIT_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MADDU = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
  localparam logic [2:0] OP_MSUBU = 3'd7;
`endif

  logic [0:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] pend;
  logic               pend_wr;

  logic               op_valid;
  logic               op_is_div;
  logic               op_wr;
  logic [2*WIDTH-1:0] op_res;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   den;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   div_r;

  // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{WIDTH{rs_data[WIDTH-1]}}, rs_data} * {{WIDTH{rt_data[WIDTH-1]}}, rt_data};
  assign prod_u = {{WIDTH{1'b0}}, rs_data} * {{WIDTH{1'b0}}, rt_data};

  // Signed divide runs on magnitudes so MIN/-1 wraps to MIN instead of overflowing.
  assign a_neg = (op == OP_DIV) & rs_data[WIDTH-1];
  assign b_neg = (op == OP_DIV) & rt_data[WIDTH-1];
  assign a_mag = a_neg ? -rs_data : rs_data;
  assign b_mag = b_neg ? -rt_data : rt_data;
  assign den   = (b_mag == '0) ? WIDTH'(1) : b_mag;
  assign q_mag = a_mag / den;
  assign r_mag = a_mag % den;
  assign div_q = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign div_r = a_neg ? -r_mag : r_mag;

  always_comb begin
    op_valid  = 1'b1;
    op_is_div = 1'b0;
    op_wr     = 1'b1;
    op_res    = prod_s;
    case (op)
      OP_MULT:  op_res = prod_s;
      OP_MULTU: op_res = prod_u;
      OP_DIV, OP_DIVU: begin
        op_is_div = 1'b1;
        op_wr     = (rt_data != '0);
        op_res    = {div_r, div_q};
      end
`ifdef MD_UNIT_MADD_EN
      OP_MADD:  op_res = {hi, lo} + prod_s;
      OP_MADDU: op_res = {hi, lo} + prod_u;
      OP_MSUB:  op_res = {hi, lo} - prod_s;
      OP_MSUBU: op_res = {hi, lo} - prod_u;
`endif
      default:  op_valid = 1'b0;
    endcase
  end

  // Handshake: start is accepted only in IDLE; busy is high for exactly LAT cycles
  // after acceptance and the new HI/LO are visible in the first cycle busy is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (op_valid) begin
              pend    <= op_res;
              pend_wr <= op_wr;
              cnt     <= op_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
              state   <= RUN;
            end
          end else begin
            if (mthi) hi <= rs_data;
            if (mtlo) lo <= rs_data;
          end
        end
        RUN: begin
          if (cnt == CNT_W'(1)) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_wr <= 1'b0;
            if (pend_wr) begin
              hi <= pend[2*WIDTH-1:WIDTH];
              lo <= pend[WIDTH-1:0];
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign md_hazard = start | busy;

endmodule
